// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer owning the architectural HI/LO registers.
// Optional feature: define MDU_FLUSH_EN to add the Flush input that aborts an operation.
module mdu_sequencer #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
`ifdef MDU_FLUSH_EN
    input  logic        Flush,
`endif
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    logic [3:0]  cnt;
    logic [1:0]  op_q;
    logic [31:0] a_q, b_q;
    logic        flush;
    logic        accept;

`ifdef MDU_FLUSH_EN
    assign flush = Flush;
`else
    assign flush = 1'b0;
`endif

    assign Busy   = (cnt != '0);
    assign accept = Start && !Busy && !flush;

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] abs_a, abs_b, q_mag, r_mag, q_s, r_s;
    logic        [31:0] res_hi, res_lo;

    // Signed division works on magnitudes, so 0x80000000 / -1 yields 0x80000000 without overflow.
    always_comb begin
        prod_s = $signed(a_q) * $signed(b_q);
        prod_u = {32'b0, a_q} * {32'b0, b_q};
        abs_a  = a_q[31] ? (~a_q + 32'd1) : a_q;
        abs_b  = b_q[31] ? (~b_q + 32'd1) : b_q;
        q_mag  = '0;
        r_mag  = '0;
        if (b_q != '0) begin
            q_mag = abs_a / abs_b;
            r_mag = abs_a % abs_b;
        end
        q_s    = (a_q[31] ^ b_q[31]) ? (~q_mag + 32'd1) : q_mag;
        r_s    = a_q[31] ? (~r_mag + 32'd1) : r_mag;
        res_hi = HI;
        res_lo = LO;
        case (op_q)
            2'd0: {res_hi, res_lo} = prod_s;
            2'd1: {res_hi, res_lo} = prod_u;
            2'd2: begin
                if (b_q != '0) begin
                    res_lo = q_s;
                    res_hi = r_s;
                end
            end
            default: begin
                if (b_q != '0) begin
                    res_lo = a_q / b_q;
                    res_hi = a_q % b_q;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            HI   <= '0;
            LO   <= '0;
        end else if (accept) begin
            case (MDOp)
                3'd0, 3'd1, 3'd2, 3'd3: begin
                    op_q <= MDOp[1:0];
                    a_q  <= A;
                    b_q  <= B;
                    cnt  <= MDOp[1] ? DIV_N : MULT_N;
                end
                3'd4:    HI <= A;
                3'd5:    LO <= A;
                default: ;
            endcase
        end else if (Busy) begin
            if (flush) begin
                cnt <= '0;
            end else begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) begin
                    HI <= res_hi;
                    LO <= res_lo;
                end
            end
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Randomized self-checking bench for mdu_sequencer against a 64-bit arithmetic reference model.
// Build with MDU_FLUSH_EN defined to also exercise the Flush scenarios.
module tb_mdu_sequencer;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Start = 1'b0;
    logic [2:0]  MDOp = '0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        Busy;
    logic [31:0] HI, LO;
`ifdef MDU_FLUSH_EN
    logic        Flush = 1'b0;
`endif

    mdu_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
`ifdef MDU_FLUSH_EN
        .Flush (Flush),
`endif
        .MDOp  (MDOp),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned passed = 0;
    int unsigned failed = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: architectural HI/LO after a completed operation, from plain 64-bit arithmetic.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: begin p = sa * sb; exp_hi = p[63:32]; exp_lo = p[31:0]; end
            3'd1: begin p = {32'b0, a} * {32'b0, b}; exp_hi = p[63:32]; exp_lo = p[31:0]; end
            3'd2: if (b != 0) begin q = sa / sb; r = sa % sb; exp_lo = q[31:0]; exp_hi = r[31:0]; end
            3'd3: if (b != 0) begin exp_lo = a / b; exp_hi = a % b; end
            3'd4: exp_hi = a;
            3'd5: exp_lo = a;
            default: ;
        endcase
    endfunction

    task automatic check_regs(input string tag);
        chk({tag, "_busy"}, {31'b0, Busy}, 32'd0);
        chk({tag, "_hi"}, HI, exp_hi);
        chk({tag, "_lo"}, LO, exp_lo);
    endtask

    // Issues one op; while Busy, optionally fires ignored Starts and scrambles A/B.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit interfere);
        int unsigned n;
        @(negedge clk);
        Start = 1'b1; MDOp = op; A = a; B = b;
        @(negedge clk);
        Start = 1'b0;
        model(op, a, b);
        if (op < 3'd4) begin
            n = (op < 3'd2) ? MC : DC;
            for (int unsigned i = 0; i < n; i++) begin
                chk($sformatf("op%0d_busy_c%0d", op, i + 1), {31'b0, Busy}, 32'd1);
                A = $urandom;
                B = $urandom;
                if (interfere) begin
                    Start = ($urandom_range(0, 1) == 1);
                    MDOp  = 3'($urandom_range(0, 7));
                    if (i == n - 1) begin
                        Start = 1'b1;
                        MDOp  = 3'd4;
                    end
                end
                @(negedge clk);
            end
            Start = 1'b0;
        end
        check_regs($sformatf("op%0d_done", op));
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;

        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_regs("reset");

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        chk("mult_hi_const", HI, 32'hFFFF_FFFF);
        chk("mult_lo_const", LO, 32'hFFFF_FFFA);

        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        chk("multu_hi_const", HI, 32'h0000_0001);
        chk("multu_lo_const", LO, 32'hFFFF_FFFE);

        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
        chk("div_lo_const", LO, 32'hFFFF_FFFD);
        chk("div_hi_const", HI, 32'hFFFF_FFFF);

        run_op(3'd4, 32'h11, 32'd0, 1'b0);
        run_op(3'd5, 32'h22, 32'd0, 1'b0);
        run_op(3'd3, 32'h1234, 32'd0, 1'b1);
        chk("divu0_hi_const", HI, 32'h11);
        chk("divu0_lo_const", LO, 32'h22);

        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_ovf_lo_const", LO, 32'h8000_0000);
        chk("div_ovf_hi_const", HI, 32'h0);

        run_op(3'd6, 32'hDEAD_BEEF, 32'd1, 1'b0);
        run_op(3'd7, 32'hDEAD_BEEF, 32'd1, 1'b0);
        repeat (3) @(negedge clk);
        check_regs("idle");

        // Reset during busy cycle 4 of a DIV aborts it with no later write.
        @(negedge clk);
        Start = 1'b1; MDOp = 3'd2; A = 32'd100; B = 32'd7;
        @(negedge clk);
        Start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_busy_c4", {31'b0, Busy}, 32'd1);
        reset = 1'b1;
        Start = 1'b1; MDOp = 3'd4;
        @(negedge clk);
        reset = 1'b0; Start = 1'b0;
        exp_hi = '0; exp_lo = '0;
        check_regs("rst_mid");
        repeat (DC + 2) @(negedge clk);
        check_regs("rst_mid_later");

`ifdef MDU_FLUSH_EN
        @(negedge clk);
        Start = 1'b1; MDOp = 3'd0; A = 32'd2; B = 32'd3;
        @(negedge clk);
        Start = 1'b0;
        chk("flush_busy_c1", {31'b0, Busy}, 32'd1);
        @(negedge clk);
        Flush = 1'b1;
        @(negedge clk);
        Flush = 1'b0;
        check_regs("flush_mid");
        repeat (MC + 2) @(negedge clk);
        check_regs("flush_later");
        Start = 1'b1; Flush = 1'b1; MDOp = 3'd4; A = 32'h55;
        @(negedge clk);
        Start = 1'b0; Flush = 1'b0;
        check_regs("flush_mthi");
`endif

        for (int k = 0; k < 40; k++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 9));
                3: b = -32'($urandom_range(1, 9));
                default: ;
            endcase
            run_op(op, a, b, ($urandom_range(0, 1) == 1));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
